// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/DM unified-memory port arbiter: FSM encodings,
// requester ids, default timing parameters and the doubleword address helper.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_ISSUE   = 2'd1;
  localparam logic [1:0] ARB_WAIT_RD = 2'd2;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 4;
  localparam int CNT_W          = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic [63:0] dw_align(input logic [63:0] addr);
    return {addr[63:3], 3'b000};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data-memory and memory-side signals around the arbiter.
// slave = arbiter view, master = pipeline/memory environment view.
interface mem_port_arbiter_if;

  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;

  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [63:0] dm_rdata;
  logic        dm_valid;
  logic        dm_stall;

  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_latency_counter.sv
// Read-latency down-counter: loaded at grant, counts down while an access is
// in flight; done marks the cycle the memory read data is valid.
module arb_latency_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LOAD_VAL = DEF_MEM_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done
);

  cnt_t cnt;

  // Load on grant, then decrement down to zero and hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= cnt_t'(0);
    end else if (load) begin
      cnt <= cnt_t'(LOAD_VAL);
    end else if (dec && (cnt != cnt_t'(0))) begin
      cnt <= cnt - cnt_t'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign done = (cnt == cnt_t'(0));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the data
// stage, sequencing one fixed-latency access at a time with starvation guard.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam cnt_t STARVE_LIM = cnt_t'(STARVE_MAX);

  logic [1:0] state;
  logic       owner;
  logic       owner_we;
  logic       if_half;
  cnt_t       starve_cnt;
  logic       take_dm;
  logic       take_if;
  logic       lat_done;
  logic       rd_done;
  logic       store_done;
  logic       if_done;
  logic       dm_done;

  // Grant decisions are only taken while idle; a starved fetch overrides DM.
  always_comb begin
    take_dm = 1'b0;
    take_if = 1'b0;
    if (state == ARB_IDLE) begin
      if (bus.dm_req && !(bus.if_req && (starve_cnt == STARVE_LIM))) begin
        take_dm = 1'b1;
      end else if (bus.if_req) begin
        take_if = 1'b1;
      end else begin
        take_dm = 1'b0;
        take_if = 1'b0;
      end
    end else begin
      take_dm = 1'b0;
      take_if = 1'b0;
    end
  end

  arb_latency_counter #(.LOAD_VAL(MEM_LAT)) u_lat (
    .clk   (clk),
    .reset (reset),
    .load  (take_dm | take_if),
    .dec   (state != ARB_IDLE),
    .done  (lat_done)
  );

  // Access sequencing; the winner and its access type stay fixed until completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      owner    <= REQ_IF;
      owner_we <= 1'b0;
      if_half  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (take_dm || take_if) begin
            state    <= ARB_ISSUE;
            owner    <= take_dm ? REQ_DM : REQ_IF;
            owner_we <= take_dm & bus.dm_we;
            if_half  <= take_if ? bus.if_addr[2] : if_half;
          end else begin
            state <= ARB_IDLE;
          end
        end
        ARB_ISSUE:   state <= store_done ? ARB_IDLE : ARB_WAIT_RD;
        ARB_WAIT_RD: state <= lat_done ? ARB_IDLE : ARB_WAIT_RD;
        default:     state <= ARB_IDLE;
      endcase
    end
  end

  // Starvation counter: counts DM wins that left a fetch waiting.
  always_ff @(posedge clk) begin
    if (reset || take_if) begin
      starve_cnt <= cnt_t'(0);
    end else if (take_dm) begin
      if (!bus.if_req) begin
        starve_cnt <= cnt_t'(0);
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + cnt_t'(1);
      end else begin
        starve_cnt <= starve_cnt;
      end
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

  // Memory strobe is a single-cycle pulse in the ISSUE cycle; address/data hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 64'h0;
      bus.mem_wdata <= 64'h0;
    end else if (take_dm || take_if) begin
      bus.mem_en    <= 1'b1;
      bus.mem_we    <= take_dm & bus.dm_we;
      bus.mem_addr  <= dw_align(take_dm ? bus.dm_addr : bus.if_addr);
      bus.mem_wdata <= take_dm ? bus.dm_wdata : bus.mem_wdata;
    end else begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= bus.mem_addr;
      bus.mem_wdata <= bus.mem_wdata;
    end
  end

  assign rd_done    = (state == ARB_WAIT_RD) && lat_done;
  assign store_done = (state == ARB_ISSUE) && (owner == REQ_DM) && owner_we;
  assign if_done    = rd_done && (owner == REQ_IF);
  assign dm_done    = store_done || (rd_done && (owner == REQ_DM));

  assign bus.if_valid = if_done;
  assign bus.dm_valid = dm_done;
  assign bus.if_rdata = if_done ? (if_half ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0]) : 32'h0;
  assign bus.dm_rdata = (rd_done && (owner == REQ_DM)) ? bus.mem_rdata : 64'h0;
  assign bus.if_stall = bus.if_req & ~if_done;
  assign bus.dm_stall = bus.dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic checked against a transaction-level timing/memory model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic reset;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // reference model: when the port is next free and what the pending access should look like
  int          free_at   = 0;
  int          starve    = 0;
  int          exp_issue = -1;
  int          exp_comp  = -1;
  bit          exp_dm    = 1'b0;
  bit          exp_we    = 1'b0;
  bit          exp_half  = 1'b0;
  logic [63:0] exp_addr  = 64'h0;
  logic [63:0] exp_wdata = 64'h0;
  logic [63:0] exp_data  = 64'h0;
  logic [63:0] ref_mem [16];

  // memory environment
  logic [63:0] env_mem [16];
  bit          sched_v [64];
  logic [63:0] sched_d [64];

  // requester agents
  bit if_seen = 1'b0, dm_seen = 1'b0;
  int if_rate = 0, dm_rate = 0, if_cont = 0, dm_cont = 0;

  // observation logs
  int          last_if_cyc = -1, last_dm_cyc = -1, if_valid_cnt = 0;
  logic [31:0] last_if_rdata = 32'h0;
  logic [63:0] en_addr_q [$];
  bit          en_we_q [$];
  int          en_cyc_q [$];
  bit          comp_log [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rnd_addr();
    return 64'($urandom_range(255));
  endfunction

  task automatic check_cycle();
    bit en_e, ifv_e, dmv_e;
    en_e  = (cyc == exp_issue);
    ifv_e = (cyc == exp_comp) && !exp_dm;
    dmv_e = (cyc == exp_comp) && exp_dm;
    chk("mem_en", bus.mem_en, en_e);
    if (en_e) begin
      chk("mem_we", bus.mem_we, exp_we);
      chk("mem_addr", bus.mem_addr, exp_addr);
      if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wdata);
    end
    chk("if_valid", bus.if_valid, ifv_e);
    chk("dm_valid", bus.dm_valid, dmv_e);
    if (ifv_e) chk("if_rdata", bus.if_rdata, exp_half ? exp_data[63:32] : exp_data[31:0]);
    if (dmv_e && !exp_we) chk("dm_rdata", bus.dm_rdata, exp_data);
    chk("if_stall", bus.if_stall, bus.if_req & ~ifv_e);
    chk("dm_stall", bus.dm_stall, bus.dm_req & ~dmv_e);
  endtask

  task automatic model_decide();
    int idx;
    if (reset) begin
      exp_issue = -1;
      exp_comp  = -1;
      free_at   = cyc + 1;
      starve    = 0;
    end else if (cyc >= free_at) begin
      if (bus.dm_req && !(bus.if_req && starve == SMAX)) begin
        starve    = bus.if_req ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
        exp_dm    = 1'b1;
        exp_we    = bus.dm_we;
        exp_addr  = {bus.dm_addr[63:3], 3'b000};
        exp_wdata = bus.dm_wdata;
        idx       = int'(bus.dm_addr[6:3]);
        if (bus.dm_we) begin
          ref_mem[idx] = bus.dm_wdata;
          exp_comp     = cyc + 1;
        end else begin
          exp_data = ref_mem[idx];
          exp_comp = cyc + 1 + LAT;
        end
        exp_issue = cyc + 1;
        free_at   = exp_comp + 1;
      end else if (bus.if_req) begin
        starve    = 0;
        exp_dm    = 1'b0;
        exp_we    = 1'b0;
        exp_addr  = {bus.if_addr[63:3], 3'b000};
        exp_half  = bus.if_addr[2];
        exp_data  = ref_mem[int'(bus.if_addr[6:3])];
        exp_issue = cyc + 1;
        exp_comp  = cyc + 1 + LAT;
        free_at   = exp_comp + 1;
      end
    end
  endtask

  task automatic observe();
    int idx;
    if (bus.mem_en === 1'b1) begin
      en_addr_q.push_back(bus.mem_addr);
      en_we_q.push_back(bus.mem_we);
      en_cyc_q.push_back(cyc);
      idx = int'(bus.mem_addr[6:3]);
      if (bus.mem_we === 1'b1) env_mem[idx] = bus.mem_wdata;
      else begin
        sched_v[(cyc + LAT) % 64] = 1'b1;
        sched_d[(cyc + LAT) % 64] = env_mem[idx];
      end
    end
    if_seen = (bus.if_valid === 1'b1);
    dm_seen = (bus.dm_valid === 1'b1);
    if (if_seen) begin
      last_if_cyc   = cyc;
      last_if_rdata = bus.if_rdata;
      if_valid_cnt++;
      comp_log.push_back(1'b0);
    end
    if (dm_seen) begin
      last_dm_cyc = cyc;
      comp_log.push_back(1'b1);
    end
  endtask

  task automatic drive_next();
    bus.mem_rdata = sched_v[cyc % 64] ? sched_d[cyc % 64] : {$urandom, $urandom};
    sched_v[cyc % 64] = 1'b0;
    if (bus.if_req && if_seen) begin
      if ($urandom_range(99) < if_cont) bus.if_addr = rnd_addr();
      else bus.if_req = 1'b0;
    end else if (!bus.if_req && $urandom_range(99) < if_rate) begin
      bus.if_req  = 1'b1;
      bus.if_addr = rnd_addr();
    end
    if (bus.dm_req && dm_seen) begin
      if ($urandom_range(99) < dm_cont) begin
        bus.dm_addr  = rnd_addr();
        bus.dm_we    = 1'($urandom_range(1));
        bus.dm_wdata = {$urandom, $urandom};
      end else bus.dm_req = 1'b0;
    end else if (!bus.dm_req && $urandom_range(99) < dm_rate) begin
      bus.dm_req   = 1'b1;
      bus.dm_addr  = rnd_addr();
      bus.dm_we    = 1'($urandom_range(1));
      bus.dm_wdata = {$urandom, $urandom};
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (chk_en) check_cycle();
    model_decide();
    observe();
    @(posedge clk);
    #1;
    cyc++;
    drive_next();
  endtask

  task automatic check_reset_state(input string pfx);
    chk({pfx, "_mem_en"},    bus.mem_en,    64'h0);
    chk({pfx, "_mem_we"},    bus.mem_we,    64'h0);
    chk({pfx, "_mem_addr"},  bus.mem_addr,  64'h0);
    chk({pfx, "_mem_wdata"}, bus.mem_wdata, 64'h0);
    chk({pfx, "_if_valid"},  bus.if_valid,  64'h0);
    chk({pfx, "_dm_valid"},  bus.dm_valid,  64'h0);
    chk({pfx, "_if_rdata"},  bus.if_rdata,  64'h0);
    chk({pfx, "_dm_rdata"},  bus.dm_rdata,  64'h0);
  endtask

  initial begin
    int t0;
    int cnt0;
    logic [63:0] v;
    for (int i = 0; i < 16; i++) begin
      v = {$urandom, $urandom};
      ref_mem[i] = v;
      env_mem[i] = v;
    end
    ref_mem[0] = 64'hAAAA_BBBB_CCCC_DDDD;
    env_mem[0] = 64'hAAAA_BBBB_CCCC_DDDD;
    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 64'h0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 64'h0; bus.dm_wdata = 64'h0;
    bus.mem_rdata = 64'h0;
    @(posedge clk);
    #1;
    step();
    step();
    check_reset_state("reset");
    chk_en = 1'b1;
    reset  = 1'b0;

    // fetch only, upper half of doubleword 0
    en_cyc_q.delete();
    bus.if_req = 1'b1; bus.if_addr = 64'h4; t0 = cyc;
    repeat (6) step();
    chk("t1_en_lat", 64'(en_cyc_q[0] - t0), 64'd1);
    chk("t1_if_lat", 64'(last_if_cyc - t0), 64'd3);
    chk("t1_if_rdata", last_if_rdata, 64'hAAAA_BBBB);

    // simultaneous fetch and load: DM first
    en_addr_q.delete();
    bus.if_req = 1'b1; bus.if_addr = 64'h8;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'h10; t0 = cyc;
    repeat (12) step();
    chk("t2_first_addr", en_addr_q[0], 64'h10);
    chk("t2_second_addr", en_addr_q[1], 64'h8);
    chk("t2_dm_lat", 64'(last_dm_cyc - t0), 64'd3);
    chk("t2_if_after_dm", 64'(last_if_cyc - last_dm_cyc), 64'd4);

    // store to unaligned address
    en_addr_q.delete(); en_we_q.delete(); en_cyc_q.delete();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 64'h1F; bus.dm_wdata = 64'h1234; t0 = cyc;
    repeat (4) step();
    chk("t3_addr", en_addr_q[0], 64'h18);
    chk("t3_we", en_we_q[0], 64'h1);
    chk("t3_valid_with_en", 64'(last_dm_cyc), 64'(en_cyc_q[0]));
    bus.dm_we = 1'b0; bus.dm_addr = 64'h18; bus.dm_req = 1'b1;
    repeat (6) step();

    // reset while a fetch waits for read data
    bus.if_req = 1'b1; bus.if_addr = 64'h20;
    step();
    step();
    cnt0 = if_valid_cnt;
    reset = 1'b1; bus.if_req = 1'b0;
    step();
    check_reset_state("abort");
    reset = 1'b0;
    repeat (5) step();
    chk("abort_no_valid", 64'(if_valid_cnt), 64'(cnt0));

    // continuous DM with fetch waiting: starvation guard
    comp_log.delete();
    if_rate = 100; dm_rate = 100; if_cont = 100; dm_cont = 100;
    bus.if_req = 1'b1; bus.if_addr = 64'h0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'h40;
    repeat (80) step();
    if_rate = 0; dm_rate = 0; if_cont = 0; dm_cont = 0;
    repeat (20) step();
    for (int i = 0; i < 10; i++)
      chk($sformatf("starve_seq_%0d", i), comp_log[i], (i % 5 == 4) ? 64'h0 : 64'h1);

    // random traffic phases
    for (int p = 0; p < 8; p++) begin
      if_rate = $urandom_range(100); dm_rate = $urandom_range(100);
      if_cont = $urandom_range(100); dm_cont = $urandom_range(100);
      repeat (50) step();
    end
    if_rate = 0; dm_rate = 0; if_cont = 0; dm_cont = 0;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
